// File: rtl/uart_pkg.sv
// Shared definitions for the UART word-assembly path.
//   BYTES_PER_WORD      : bytes packed into one assembled word (MSB first)
//   BYTE_IDX_W          : width of the byte index inside a word
//   DEFAULT_GAP_TIMEOUT : default inter-byte silence limit, in clocks
//   state_e             : byte-collection FSM states
package uart_pkg;

  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned BYTE_IDX_W          = 2;
  localparam logic [31:0] DEFAULT_GAP_TIMEOUT = 32'd9999999;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/uart_word_assembler_if.sv
// Byte-in / word-out bundle of the UART word assembler.
//   rx_data/rx_done : received byte and its one-cycle completion strobe
//   data_out        : last assembled 32-bit word
//   word_valid      : a word is pending on data_out
//   word_ack        : consumer has taken the pending word
//   overrun         : pulse, new word completed over an unacknowledged one
//   timeout         : pulse, a partial word was discarded
// slave  = the assembler; master = the RX engine / consumer side.
interface uart_word_assembler_if;

  logic [7:0]  rx_data;
  logic        rx_done;
  logic [31:0] data_out;
  logic        word_valid;
  logic        word_ack;
  logic        overrun;
  logic        timeout;

  modport master (
    output rx_data, rx_done, word_ack,
    input  data_out, word_valid, overrun, timeout
  );

  modport slave (
    input  rx_data, rx_done, word_ack,
    output data_out, word_valid, overrun, timeout
  );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer.
//   clk, rst  : clock, asynchronous active-low reset
//   clr_i     : clear the count (takes priority over en_i)
//   en_i      : count one clock of silence
//   expired_o : high in the cycle whose increment would reach TIMEOUT;
//               the count clears on that same edge
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [31:0] cnt_q, cnt_d;

  // Comparing against TIMEOUT-1 lets the owner act on the very edge at
  // which the count would become TIMEOUT, so the count never wraps.
  always_comb begin
    expired_o = en_i && !clr_i && (cnt_q == (TIMEOUT - 32'd1));
    cnt_d     = cnt_q;
    if (clr_i || expired_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// Reassembles UART RX bytes, MSB first, into 32-bit words with a
// valid/ack handshake; partial words are dropped after an inter-byte gap.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of uart_word_assembler_if (byte strobe in,
//              word/valid/ack handshake, overrun and timeout pulses out)
//   TIMEOUT  : clocks of silence tolerated between bytes of one word
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_word_assembler_if.slave  bus
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [31:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  timeout_q, timeout_d;

  logic gap_clr, gap_en, gap_hit;

  // A strobe in the expiry cycle clears the timer, so the byte wins.
  assign gap_clr = (state_q == ST_IDLE) || bus.rx_done;
  assign gap_en  = (state_q == ST_COLLECT) && !bus.rx_done;

  uart_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (gap_clr),
    .en_i      (gap_en),
    .expired_o (gap_hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    timeout_d = 1'b0;

    if (valid_q && bus.word_ack) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.rx_done) begin
          shreg_d[31:24] = bus.rx_data;
          idx_d          = BYTE_IDX_W'(1);
          state_d        = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (bus.rx_done) begin
          if (idx_q == LAST_IDX) begin
            data_d    = {shreg_q[31:8], bus.rx_data};
            // Completing word overrides any same-cycle ack clear above.
            overrun_d = valid_q && !bus.word_ack;
            valid_d   = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            unique case (idx_q)
              BYTE_IDX_W'(1): shreg_d[23:16] = bus.rx_data;
              BYTE_IDX_W'(2): shreg_d[15:8]  = bus.rx_data;
              default:        shreg_d[31:24] = bus.rx_data;
            endcase
            idx_d = idx_q + BYTE_IDX_W'(1);
          end
        end else if (gap_hit) begin
          timeout_d = 1'b1;
          idx_d     = '0;
          shreg_d   = '0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.word_valid = valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
module tb_uart_word_assembler;

  localparam int TMO = 150;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  uart_word_assembler_if bus ();

  uart_word_assembler #(
    .TIMEOUT (32'(TMO))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected in arrival order, word emitted once
  // four have arrived, partial word forgotten after TMO silent cycles.
  logic [7:0]  m_bytes [4];
  int          m_n       = 0;
  int          cyc       = 0;
  int          last_cyc  = 0;
  logic [31:0] exp_word  = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ov    = 1'b0;
  logic        exp_to    = 1'b0;
  logic        old_valid;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_n = 0; exp_word = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_to = 1'b0;
      end else begin
        cyc++;
        old_valid = exp_valid;
        exp_ov = 1'b0;
        exp_to = 1'b0;
        if (old_valid && bus.word_ack) exp_valid = 1'b0;
        if (bus.rx_done) begin
          m_bytes[m_n] = bus.rx_data;
          m_n++;
          last_cyc = cyc;
          if (m_n == 4) begin
            exp_word  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            exp_ov    = old_valid && !bus.word_ack;
            exp_valid = 1'b1;
            m_n = 0;
          end
        end else if (m_n > 0 && (cyc - last_cyc) == TMO) begin
          m_n = 0;
          exp_to = 1'b1;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic ack);
    bus.rx_done  = 1'b1;
    bus.rx_data  = b;
    bus.word_ack = ack;
    @(negedge clk);
    bus.rx_done  = 1'b0;
    bus.word_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.word_ack = 1'b1;
    @(negedge clk);
    bus.word_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(3);
    total++; if (bus.data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.data_out); end
    total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.word_valid); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.overrun); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", bus.timeout); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_spaced_word();
    logic [7:0] b [4];
    b[0] = 8'h0F; b[1] = 8'h18; b[2] = 8'h37; b[3] = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k], 1'b0);
      if (k < 3) idle(99);
    end
    total++; if (bus.data_out !== 32'h0F1837FE) begin bad++; $display("FAIL spaced_data got=%h want=0f1837fe", bus.data_out); end
    total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL spaced_valid got=%b want=1", bus.word_valid); end
    ack_pulse();
    total++; if (bus.word_valid !== 1'b0) begin bad++; $display("FAIL spaced_ack got=%b want=0", bus.word_valid); end
    total++; if (bus.data_out !== exp_word) begin bad++; $display("FAIL spaced_hold got=%h want=%h", bus.data_out, exp_word); end
  endtask

  task automatic test_random_traffic();
    int errs = 0;
    for (int i = 0; i < 800; i++) begin
      bus.rx_done  = ($urandom_range(0, 3) == 0);
      bus.rx_data  = 8'($urandom);
      bus.word_ack = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      total++;
      if (bus.data_out !== exp_word || bus.word_valid !== exp_valid ||
          bus.overrun !== exp_ov || bus.timeout !== exp_to) begin
        bad++;
        if (errs++ < 5)
          $display("FAIL random_cycle%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", i,
                   bus.data_out, bus.word_valid, bus.overrun, bus.timeout,
                   exp_word, exp_valid, exp_ov, exp_to);
      end
    end
    bus.rx_done = 1'b0;
    bus.word_ack = 1'b0;
    idle(TMO + 2);
  endtask

  task automatic test_gap_timeout();
    int n_to = 0;
    ack_pulse();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    for (int i = 0; i < TMO + 5; i++) begin
      @(negedge clk);
      if (bus.timeout) n_to++;
      total++;
      if (bus.timeout !== exp_to) begin
        bad++; $display("FAIL gap_pulse_cycle%0d got=%b want=%b", i, bus.timeout, exp_to);
      end
    end
    total++; if (n_to != 1) begin bad++; $display("FAIL gap_pulse_count got=%0d want=1", n_to); end
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    total++; if (bus.data_out !== 32'h01020304) begin bad++; $display("FAIL gap_data got=%h want=01020304", bus.data_out); end
    total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL gap_valid got=%b want=1", bus.word_valid); end
  endtask

  task automatic test_overrun();
    int n_ov = 0;
    logic [31:0] w [2];
    w[0] = 32'h11223344; w[1] = 32'h55667788;
    ack_pulse();
    for (int k = 0; k < 8; k++) begin
      send_byte(w[k/4][31-8*(k%4) -: 8], 1'b0);
      if (bus.overrun) n_ov++;
    end
    idle(1);
    if (bus.overrun) n_ov++;
    total++; if (n_ov != 1) begin bad++; $display("FAIL ovr_count got=%0d want=1", n_ov); end
    total++; if (bus.data_out !== 32'h55667788) begin bad++; $display("FAIL ovr_data got=%h want=55667788", bus.data_out); end
    ack_pulse();
    n_ov = 0;
    for (int k = 0; k < 8; k++) begin
      send_byte(w[k/4][31-8*(k%4) -: 8], (k == 7));
      if (bus.overrun) n_ov++;
    end
    idle(1);
    if (bus.overrun) n_ov++;
    total++; if (n_ov != 0) begin bad++; $display("FAIL ovr_ack_count got=%0d want=0", n_ov); end
    total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL ovr_ack_valid got=%b want=1", bus.word_valid); end
    total++; if (bus.data_out !== 32'h55667788) begin bad++; $display("FAIL ovr_ack_data got=%h want=55667788", bus.data_out); end
  endtask

  task automatic test_back_to_back();
    ack_pulse();
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    total++; if (bus.data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_data got=%h want=deadbeef", bus.data_out); end
    total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", bus.word_valid); end
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b0;
    bus.rx_done = 1'b1;
    bus.rx_data = 8'h99;
    idle(2);
    total++; if (bus.data_out !== 32'h0 || bus.word_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.timeout !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got=%h/%b/%b/%b want=0/0/0/0", bus.data_out, bus.word_valid, bus.overrun, bus.timeout);
    end
    bus.rx_done = 1'b0;
    rst = 1'b1;
    idle(1);
    send_byte(8'hCA, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hBA, 1'b0);
    send_byte(8'hBE, 1'b0);
    total++; if (bus.data_out !== 32'hCAFEBABE) begin bad++; $display("FAIL midrst_data got=%h want=cafebabe", bus.data_out); end
  endtask

  task automatic test_exact_timeout();
    logic [7:0]  b [4];
    logic [31:0] want;
    int n_to = 0;
    ack_pulse();
    for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
    want = {b[0], b[1], b[2], b[3]};
    for (int k = 0; k < 4; k++) begin
      send_byte(b[k], 1'b0);
      if (bus.timeout) n_to++;
      if (k < 3) begin
        for (int i = 0; i < TMO - 1; i++) begin
          @(negedge clk);
          if (bus.timeout) n_to++;
        end
      end
    end
    total++; if (n_to != 0) begin bad++; $display("FAIL edge_timeout_count got=%0d want=0", n_to); end
    total++; if (bus.data_out !== want) begin bad++; $display("FAIL edge_data got=%h want=%h", bus.data_out, want); end
    total++; if (bus.word_valid !== 1'b1) begin bad++; $display("FAIL edge_valid got=%b want=1", bus.word_valid); end
  endtask

  initial begin
    bus.rx_done  = 1'b0;
    bus.rx_data  = 8'h00;
    bus.word_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_spaced_word();
    test_random_traffic();
    test_gap_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid_word();
    test_exact_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_word_assembler.md
# uart_word_assembler

Receive-side counterpart of the 32-bit-over-UART byte sender. It takes bytes strobed out of a UART receiver and reassembles them MSB-first into 32-bit words. It presents each word with a valid/acknowledge handshake and discards partial words after an inter-byte gap timeout. It sits between the UART RX byte engine and any consumer of host-sent 32-bit commands or samples, for example loopback checking of the sensor data stream.

## Interface
- `TIMEOUT`, default 32'd9999999: clocks of silence allowed between bytes of one word before the partial word is dropped. It is 2× the sender's byte spacing.
- `BYTES`, fixed 4: bytes per word. This is a package constant, not overridable.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: reset, asynchronous, active-low.
- `rx_data`  in  8: received byte. Valid only while `rx_done`=1.
- `rx_done`  in  1: one-cycle strobe from the UART receiver meaning a byte is complete.
- `data_out`  out  32: last assembled word. Held stable until the next word completes.
- `word_valid`  out  1: a word is pending on `data_out`.
- `word_ack`  in  1: consumer has taken the word. Only meaningful while `word_valid`=1.
- `overrun`  out  1: one-cycle pulse when a new word completes while the previous word is still unacknowledged.
- `timeout`  out  1: one-cycle pulse when a partial word is discarded.

## Operation
- Two-state FSM:
  - IDLE: byte index 0, gap timer stopped.
  - COLLECT: byte index 1..3, gap timer running.
- IDLE + `rx_done`: shift `rx_data` into `shreg[31:24]`, set index=1, clear the gap counter, and go to COLLECT.
- COLLECT + `rx_done`, index<3:
  - Shift the byte in at the next lower lane. Byte k lands in `shreg[31-8k -: 8]`.
  - Increment the index and clear the gap counter.
- COLLECT + `rx_done`, index=3:
  - `data_out` ← {`shreg[31:8]`, `rx_data`}.
  - Set `word_valid` to 1, set index to 0, and return to IDLE.
  - If `word_valid` was already 1 and `word_ack`=0 in this same cycle, also pulse `overrun`. The new word overwrites the old one.
- COLLECT, no `rx_done`: gap counter +1. When the counter equals `TIMEOUT`:
  - Pulse `timeout`, clear the index and the shift register, and go to IDLE.
  - `data_out` and `word_valid` are unaffected.
- `word_ack` while `word_valid`=1 clears `word_valid` on the next edge. `word_ack` while `word_valid`=0 is ignored.
- Gap counter is 32 bits, compared with `==`. It never wraps, because it is cleared on the timeout.

## Timing
- All outputs are registered. Reset values:
  - `data_out`=0, `word_valid`=0, `overrun`=0, `timeout`=0.
  - FSM=IDLE, index=0, gap counter=0.
- Latency: the 4th `rx_done` is sampled at edge N. `data_out` and `word_valid` are updated at edge N, so they are visible from cycle N+1.
- Simultaneous events:
  - 4th byte and `word_ack` in the same cycle: `word_valid` stays 1 with the new word, and there is no `overrun`.
  - `rx_done` in the cycle the gap counter would hit `TIMEOUT`: the byte is accepted and the counter is cleared, with no `timeout` pulse.
  - `rx_done` on back-to-back cycles: each one is accepted. No bubble is required.
- Reset asserted mid-word: the partial word is lost and all state returns to its reset value immediately. `rx_done` is ignored while `rst`=0.

## Structure
- Shared package (`uart_pkg`) holds:
  - `BYTES_PER_WORD`=4.
  - `BYTE_IDX_W`=2.
  - `DEFAULT_GAP_TIMEOUT`=32'd9999999.
  - The FSM state encoding (IDLE, COLLECT).
- One natural sub-module, `uart_gap_timer`: a clearable counter with an enable and a one-cycle `expired` pulse at `TIMEOUT`. The byte FSM, shift register and handshake stay in the top module.

## Test plan
- Bytes 0x0F, 0x18, 0x37, 0xFE, spaced 100 clocks apart → `data_out`=0x0F1837FE and `word_valid`=1 one cycle after the 4th strobe. `word_ack` → `word_valid`=0 on the next cycle.
- Bytes 0xAA, 0xBB, then a gap of `TIMEOUT`+5 clocks, then 0x01, 0x02, 0x03, 0x04 → one `timeout` pulse and `data_out`=0x01020304. 0xAA/0xBB never appear on the output.
- Two full words with no `word_ack` in between (0x11223344, then 0x55667788) → `overrun` pulses once and `data_out`=0x55667788. Repeat with `word_ack` in the cycle of the 4th byte → no `overrun`.
- `rx_done` asserted on 4 consecutive cycles with bytes 0xDE, 0xAD, 0xBE, 0xEF → `data_out`=0xDEADBEEF, with no bytes dropped.
- `rst` pulled low after 2 bytes, then 4 new bytes 0xCA, 0xFE, 0xBA, 0xBE → all outputs 0 during reset, then `data_out`=0xCAFEBABE.
- A byte arriving exactly when the gap counter reaches `TIMEOUT` → no `timeout` pulse, and the word completes normally.
